// File: rtl/hdmi_audio_pkg.sv
// Shared constants and types for the HDMI audio sample receive path.
package hdmi_audio_pkg;

    localparam logic [7:0] PKT_TYPE_AUDIO_SAMPLE    = 8'h02;
    localparam logic [7:0] PKT_TYPE_ACR             = 8'h01;
    localparam logic [7:0] PKT_TYPE_AUDIO_INFOFRAME = 8'h84;

    localparam int unsigned NUM_SUBPACKETS = 4;
    localparam int unsigned SUB_WIDTH      = 56;
    localparam int unsigned SAMPLE_WIDTH   = 24;
    localparam int unsigned CS_FRAMES      = 192;

    localparam int unsigned SUB_LEFT_LSB  = 0;
    localparam int unsigned SUB_RIGHT_LSB = 24;
    localparam int unsigned SUB_V_LEFT    = 48;
    localparam int unsigned SUB_U_LEFT    = 49;
    localparam int unsigned SUB_C_LEFT    = 50;
    localparam int unsigned SUB_P_LEFT    = 51;
    localparam int unsigned SUB_V_RIGHT   = 52;
    localparam int unsigned SUB_U_RIGHT   = 53;
    localparam int unsigned SUB_C_RIGHT   = 54;
    localparam int unsigned SUB_P_RIGHT   = 55;

    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] right;
        logic [SAMPLE_WIDTH-1:0] left;
    } stereo_sample_t;

    typedef enum logic {
        IN_IDLE,
        IN_UNPACK
    } in_state_t;

    typedef enum logic {
        OUT_PREFILL,
        OUT_RUN
    } out_state_t;

    // Even parity over the sample and its V,U,C,P bits.
    function automatic logic channel_parity_ok(input logic [SAMPLE_WIDTH-1:0] sample,
                                               input logic [3:0] vucp);
        return ~(^{sample, vucp});
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock FIFO of stereo samples with show-ahead read data and occupancy.
module audio_sample_fifo
    import hdmi_audio_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_audio,
    input  logic                       reset,
    input  logic                       wr_en,
    input  stereo_sample_t             wr_data,
    input  logic                       rd_en,
    output stereo_sample_t             rd_data_c,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    stereo_sample_t   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk_audio) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clk_audio) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/hdmi_audio_sample_unpacker.sv
// Unpacks 2-channel audio sample packets into a FIFO, collects left-channel
// status bits and streams one stereo sample per clk_audio cycle.
module hdmi_audio_sample_unpacker
    import hdmi_audio_pkg::*;
#(
    parameter int unsigned AUDIO_BIT_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned PREFILL         = 8
) (
    input  logic                            clk_audio,
    input  logic                            reset,
    input  logic                            pkt_valid,
    output logic                            pkt_ready,
    input  logic [23:0]                     pkt_header,
    input  logic [3:0][SUB_WIDTH-1:0]       pkt_sub,
    output logic [1:0][AUDIO_BIT_WIDTH-1:0] audio_sample_word,
    output logic                            audio_valid,
    output logic [CS_FRAMES-1:0]            channel_status,
    output logic                            channel_status_valid,
    output logic                            parity_error,
    output logic                            underrun,
    output logic                            dropped
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_W = 8;

    in_state_t                 in_state, in_next;
    out_state_t                out_state, out_next;
    logic [1:0]                idx;
    logic [3:0]                present_q, flat_q, b_q;
    logic [3:0][SUB_WIDTH-1:0] sub_q;
    logic [SUB_WIDTH-1:0]      cur_sub;
    logic                      accept, latch, drop, parity_fail, ready_next;
    logic                      left_ok, right_ok;
    logic                      wr_en, rd_en, run_empty;
    stereo_sample_t            wr_data, rd_data_c;
    logic [CNT_W-1:0]          occ, occ_next;
    logic [IDX_W-1:0]          frame_idx;
    logic [CS_FRAMES-1:0]      cs_shift;
    logic                      unused_bits;

    assign accept   = pkt_valid && pkt_ready;
    assign cur_sub  = sub_q[idx];
    assign left_ok  = channel_parity_ok(cur_sub[SUB_LEFT_LSB +: SAMPLE_WIDTH], cur_sub[SUB_V_LEFT +: 4]);
    assign right_ok = channel_parity_ok(cur_sub[SUB_RIGHT_LSB +: SAMPLE_WIDTH], cur_sub[SUB_V_RIGHT +: 4]);
    assign occ_next = occ + CNT_W'(wr_en) - CNT_W'(rd_en);
    assign ready_next = (in_next == IN_IDLE) && (occ_next <= CNT_W'(FIFO_DEPTH - 4));
    assign unused_bits = ^{pkt_header[15:13], rd_data_c};

    // Input FSM: admit packets, then write one subpacket per cycle.
    always_comb begin
        in_next     = in_state;
        latch       = 1'b0;
        drop        = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        parity_fail = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (accept && (pkt_header[7:0] == PKT_TYPE_AUDIO_SAMPLE)) begin
                    if (pkt_header[12]) begin
                        drop = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        in_next = IN_UNPACK;
                    end
                end
            end
            IN_UNPACK: begin
                if (present_q[idx]) begin
                    wr_en = 1'b1;
                    if (!flat_q[idx]) begin
                        if (left_ok) begin
                            wr_data.left = cur_sub[SUB_LEFT_LSB +: SAMPLE_WIDTH];
                        end
                        if (right_ok) begin
                            wr_data.right = cur_sub[SUB_RIGHT_LSB +: SAMPLE_WIDTH];
                        end
                        parity_fail = !left_ok || !right_ok;
                    end
                end
                if (idx == 2'd3) begin
                    in_next = IN_IDLE;
                end
            end
            default: in_next = IN_IDLE;
        endcase
    end

    always_ff @(posedge clk_audio) begin
        if (reset) begin
            in_state     <= IN_IDLE;
            idx          <= '0;
            present_q    <= '0;
            flat_q       <= '0;
            b_q          <= '0;
            sub_q        <= '0;
            pkt_ready    <= 1'b0;
            dropped      <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            in_state     <= in_next;
            pkt_ready    <= ready_next;
            dropped      <= drop;
            parity_error <= parity_fail;
            if (latch) begin
                present_q <= pkt_header[11:8];
                flat_q    <= pkt_header[19:16];
                b_q       <= pkt_header[23:20];
                sub_q     <= pkt_sub;
                idx       <= '0;
            end else if (in_state == IN_UNPACK) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Channel status: frame 0 enters at the top and shifts down to bit 0.
    always_ff @(posedge clk_audio) begin
        if (reset) begin
            frame_idx            <= '0;
            cs_shift             <= '0;
            channel_status       <= '0;
            channel_status_valid <= 1'b0;
        end else begin
            channel_status_valid <= 1'b0;
            if (wr_en) begin
                if (b_q[idx]) begin
                    if (frame_idx == IDX_W'(CS_FRAMES)) begin
                        channel_status       <= cs_shift;
                        channel_status_valid <= 1'b1;
                    end
                    cs_shift  <= {cur_sub[SUB_C_LEFT], (CS_FRAMES-1)'(0)};
                    frame_idx <= IDX_W'(1);
                end else if (frame_idx != IDX_W'(CS_FRAMES)) begin
                    cs_shift  <= {cur_sub[SUB_C_LEFT], cs_shift[CS_FRAMES-1:1]};
                    frame_idx <= frame_idx + IDX_W'(1);
                end
            end
        end
    end

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_audio (clk_audio),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data_c (rd_data_c),
        .count     (occ)
    );

    // Output FSM: hold until prefilled, then drain one entry per cycle.
    always_comb begin
        out_next  = out_state;
        rd_en     = 1'b0;
        run_empty = 1'b0;
        case (out_state)
            OUT_PREFILL: begin
                if (occ >= CNT_W'(PREFILL)) begin
                    out_next = OUT_RUN;
                end
            end
            OUT_RUN: begin
                if (occ == '0) begin
                    run_empty = 1'b1;
                    out_next  = OUT_PREFILL;
                end else begin
                    rd_en = 1'b1;
                end
            end
            default: out_next = OUT_PREFILL;
        endcase
    end

    always_ff @(posedge clk_audio) begin
        if (reset) begin
            out_state         <= OUT_PREFILL;
            audio_sample_word <= '0;
            audio_valid       <= 1'b0;
            underrun          <= 1'b0;
        end else begin
            out_state   <= out_next;
            audio_valid <= rd_en;
            underrun    <= run_empty;
            if (rd_en) begin
                audio_sample_word[0] <= rd_data_c.left[SAMPLE_WIDTH-1 -: AUDIO_BIT_WIDTH];
                audio_sample_word[1] <= rd_data_c.right[SAMPLE_WIDTH-1 -: AUDIO_BIT_WIDTH];
            end else begin
                audio_sample_word <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_audio_sample_unpacker.sv
// Directed and randomized checks of the audio sample unpacker against a
// packet-level reference model and an output scoreboard.
module tb_hdmi_audio_sample_unpacker;

    localparam int unsigned W   = 16;
    localparam int unsigned DEP = 16;
    localparam int unsigned PRE = 8;

    logic                clk_audio = 1'b0;
    logic                reset;
    logic                pkt_valid;
    logic                pkt_ready;
    logic [23:0]         pkt_header;
    logic [3:0][55:0]    pkt_sub;
    logic [1:0][W-1:0]   audio_sample_word;
    logic                audio_valid;
    logic [191:0]        channel_status;
    logic                channel_status_valid;
    logic                parity_error;
    logic                underrun;
    logic                dropped;

    always #5 clk_audio = ~clk_audio;

    hdmi_audio_sample_unpacker #(
        .AUDIO_BIT_WIDTH (W),
        .FIFO_DEPTH      (DEP),
        .PREFILL         (PRE)
    ) dut (
        .clk_audio            (clk_audio),
        .reset                (reset),
        .pkt_valid            (pkt_valid),
        .pkt_ready            (pkt_ready),
        .pkt_header           (pkt_header),
        .pkt_sub              (pkt_sub),
        .audio_sample_word    (audio_sample_word),
        .audio_valid          (audio_valid),
        .channel_status       (channel_status),
        .channel_status_valid (channel_status_valid),
        .parity_error         (parity_error),
        .underrun             (underrun),
        .dropped              (dropped)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model state
    logic [2*W-1:0] exp_q[$];
    logic [191:0]   exp_cs_q[$];
    logic [191:0]   frames_v = '0;
    int             frame_cnt = 0;
    int             exp_par = 0, exp_drop = 0, exp_cs = 0;

    // observations
    int             got_par = 0, got_drop = 0, got_cs = 0;
    int             valid_cyc[$];
    int             underrun_cyc[$];
    logic [2*W-1:0] out_words[$];
    logic [2*W-1:0] mon_e;
    logic [191:0]   mon_cs;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] mk_sub(input logic [23:0] l, input logic [23:0] r,
                                           input logic c, input logic bad_l, input logic bad_r);
        logic pl, pr;
        pl = (^{l, 1'b0, 1'b0, c}) ^ bad_l;
        pr = (^r) ^ bad_r;
        return {pr, 1'b0, 1'b0, 1'b0, pl, c, 1'b0, 1'b0, r, l};
    endfunction

    function automatic logic [23:0] mk_hdr(input logic [7:0] typ, input logic [3:0] present,
                                           input logic layout, input logic [3:0] flat,
                                           input logic [3:0] b);
        return {b, flat, 3'b000, layout, present, typ};
    endfunction

    function automatic logic [23:0] seq_l(input int k);
        return 24'h123456 + 24'(k) * 24'h010101;
    endfunction

    function automatic logic [23:0] seq_r(input int k);
        return 24'hABCDEF + 24'(k) * 24'h010101;
    endfunction

    // Expected effect of one accepted packet, straight from the packet rules.
    function automatic void model_accept(input logic [23:0] h, input logic [3:0][55:0] s);
        logic [23:0] l, r;
        logic        ok_l, ok_r;
        if (h[7:0] != 8'h02) return;
        if (h[12]) begin
            exp_drop++;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (h[8+i]) begin
                l    = s[i][23:0];
                r    = s[i][47:24];
                ok_l = ((^{l, s[i][51:48]}) == 1'b0);
                ok_r = ((^{r, s[i][55:52]}) == 1'b0);
                if (h[16+i]) begin
                    exp_q.push_back('0);
                end else begin
                    exp_q.push_back({ok_r ? W'(r >> (24 - W)) : W'(0),
                                     ok_l ? W'(l >> (24 - W)) : W'(0)});
                    if (!ok_l || !ok_r) exp_par++;
                end
                if (h[20+i]) begin
                    if (frame_cnt == 192) begin
                        exp_cs_q.push_back(frames_v);
                        exp_cs++;
                    end
                    frames_v    = '0;
                    frames_v[0] = s[i][50];
                    frame_cnt   = 1;
                end else if (frame_cnt < 192) begin
                    frames_v[frame_cnt] = s[i][50];
                    frame_cnt++;
                end
            end
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [23:0] h, input logic [3:0][55:0] s);
        int waited = 0;
        pkt_header = h;
        pkt_sub    = s;
        pkt_valid  = 1'b1;
        while (!pkt_ready && waited < 100) begin
            @(negedge clk_audio);
            waited++;
        end
        if (!pkt_ready) begin
            check("ready_timeout", pkt_ready, 1);
        end else begin
            @(posedge clk_audio);
            model_accept(h, s);
            @(negedge clk_audio);
        end
        pkt_valid = 1'b0;
    endtask

    task automatic check_ready_window(input string tag);
        check(tag, pkt_ready, 0);
        repeat (3) begin
            @(negedge clk_audio);
            check(tag, pkt_ready, 0);
        end
        @(negedge clk_audio);
        check({tag, "_reopen"}, pkt_ready, 1);
    endtask

    // Output scoreboard and pulse counters.
    always @(negedge clk_audio) begin
        cyc++;
        if (!reset) begin
            if (audio_valid) begin
                valid_cyc.push_back(cyc);
                out_words.push_back(audio_sample_word);
                mon_e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                check("sample", audio_sample_word, mon_e);
            end else begin
                check("fill_zero", audio_sample_word, 0);
            end
            if (underrun) begin
                underrun_cyc.push_back(cyc);
                check("underrun_valid_low", audio_valid, 0);
            end
            if (parity_error) got_par++;
            if (dropped) got_drop++;
            if (channel_status_valid) begin
                got_cs++;
                mon_cs = (exp_cs_q.size() != 0) ? exp_cs_q.pop_front() : 'x;
                check("channel_status", channel_status, mon_cs);
            end
        end
    end

    initial begin
        logic [3:0][55:0] s;
        logic [191:0]     pat;
        logic [7:0]       cpat;
        logic [7:0]       typ;
        logic [3:0]       bsel;
        int               k, seq, f;

        reset      = 1'b1;
        pkt_valid  = 1'b0;
        pkt_header = '0;
        pkt_sub    = '0;
        repeat (3) @(negedge clk_audio);
        check("ready_in_reset", pkt_ready, 0);
        check("valid_in_reset", audio_valid, 0);
        reset = 1'b0;
        @(negedge clk_audio);
        check("ready_after_reset", pkt_ready, 1);
        check("word_after_reset", audio_sample_word, 0);
        check("cs_after_reset", channel_status, 0);
        check("pulses_after_reset", {channel_status_valid, parity_error, underrun, dropped}, 0);

        // back-to-back full packets; subpacket 1 of packet 1 has a bad left parity
        seq = 0;
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 4; i++) begin
                s[i] = mk_sub(seq_l(seq), seq_r(seq), 1'b0, (p == 1 && i == 1), 1'b0);
                seq++;
            end
            send(mk_hdr(8'h02, 4'hF, 1'b0, 4'h0, 4'h0), s);
            if (p == 0) check_ready_window("ready_unpack");
        end

        k = 0;
        while (underrun_cyc.size() == 0 && k < 200) begin
            @(negedge clk_audio);
            k++;
        end
        check("underrun_seen", underrun_cyc.size(), 1);
        check("run_length", valid_cyc.size(), 24);
        check("run_continuous", valid_cyc[23] - valid_cyc[0], 23);
        check("underrun_timing", underrun_cyc[0] - valid_cyc[23], 1);
        check("first_word", out_words[0], 32'hABCD_1234);
        check("parity_left_zeroed", out_words[5], {W'(seq_r(5) >> (24 - W)), W'(0)});
        check("parity_pulses", got_par, 1);

        // resume needs PREFILL fresh samples
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                s[i] = mk_sub(seq_l(seq), seq_r(seq), 1'b0, 1'b0, 1'b0);
                seq++;
            end
            send(mk_hdr(8'h02, 4'hF, 1'b0, 4'h0, 4'h0), s);
            if (p == 0) begin
                repeat (20) @(negedge clk_audio);
                check("no_early_resume", valid_cyc.size(), 24);
            end
        end
        k = 0;
        while (valid_cyc.size() < 32 && k < 60) begin
            @(negedge clk_audio);
            k++;
        end
        check("resume_count", valid_cyc.size(), 32);
        check("resume_continuous", valid_cyc[31] - valid_cyc[24], 7);
        repeat (4) @(negedge clk_audio);
        check("second_underrun", underrun_cyc.size(), 2);

        // sparse present mask, foreign packet type and layout-1 discard
        for (int i = 0; i < 4; i++) begin
            s[i] = mk_sub(seq_l(seq), seq_r(seq), 1'b0, 1'b0, 1'b0);
            seq++;
        end
        send(mk_hdr(8'h02, 4'b0101, 1'b0, 4'h0, 4'h0), s);
        check_ready_window("ready_sparse");
        send(mk_hdr(8'h84, 4'hF, 1'b0, 4'h0, 4'h0), s);
        check("aif_ready", pkt_ready, 1);
        check("aif_no_drop", dropped, 0);
        send(mk_hdr(8'h02, 4'hF, 1'b1, 4'h0, 4'h0), s);
        check("layout_ready", pkt_ready, 1);
        check("layout_drop", dropped, 1);

        // channel status: full block, early B at frame 100, then a block from there
        cpat = 8'hA5;
        for (int i = 0; i < 192; i++) pat[i] = cpat[i % 8];
        for (int p = 0; p < 122; p++) begin
            for (int i = 0; i < 4; i++) begin
                f    = 4 * p + i;
                s[i] = mk_sub(24'($urandom), 24'($urandom), cpat[f % 8], 1'b0, 1'b0);
            end
            bsel = (p == 0 || p == 48 || p == 73 || p == 121) ? 4'b0001 : 4'b0000;
            send(mk_hdr(8'h02, 4'hF, 1'b0, 4'h0, bsel), s);
            if (p == 48) begin
                repeat (3) @(negedge clk_audio);
                check("cs_block_pulse", got_cs, 1);
                check("cs_block_value", channel_status, pat);
            end
            if (p == 74) check("cs_early_b_no_pulse", got_cs, 1);
        end
        repeat (3) @(negedge clk_audio);
        check("cs_after_restart", got_cs, 2);

        // randomized packets with gaps
        for (int p = 0; p < 60; p++) begin
            for (int i = 0; i < 4; i++) begin
                s[i] = mk_sub(24'($urandom), 24'($urandom), 1'($urandom),
                              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            end
            k    = $urandom_range(0, 9);
            typ  = (k == 0) ? 8'h84 : (k == 1) ? 8'h01 : 8'h02;
            bsel = 4'b0000;
            for (int i = 0; i < 4; i++) bsel[i] = ($urandom_range(0, 15) == 0);
            send(mk_hdr(typ, 4'($urandom), ($urandom_range(0, 9) == 0),
                        4'($urandom) & 4'($urandom), bsel), s);
            repeat ($urandom_range(0, 3)) @(negedge clk_audio);
        end

        repeat (100) @(negedge clk_audio);
        check("leftover_below_prefill", (exp_q.size() < PRE), 1);
        check("parity_pulse_total", got_par, exp_par);
        check("dropped_pulse_total", got_drop, exp_drop);
        check("cs_pulse_total", got_cs, exp_cs);
        check("cs_queue_empty", exp_cs_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
